serdes_framed: RTL and testbench

Parametrised, framed serializer/deserializer pair: the next generation of the fixed 8-bit `serdes_top` datapath. It adds a configurable word width and bit order, a valid/ready handshake on the parallel transmit side, and an explicit frame strobe that marks word boundaries on the serial link. It also provides frame-error detection and an internal loopback. It sits between the parallel pin bus and the serial pins of the chip top.

---
 rtl/serdes_framed.sv | 166 ++++++++++++++++
 tb/tb_serdes_framed.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_framed.sv
// Framed serializer/deserializer with a valid/ready transmit handshake, a frame strobe on the
// first bit of every word, sticky framing-error detection and an internal loopback path.
module serdes_framed #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             ser_out,
    output logic             ser_frame,
    input  logic             ser_in,
    input  logic             ser_frame_in,
    input  logic             loopback,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_err
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = CW'(1'b1);

    typedef enum logic [0:0] {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_e;

    // Serial position i maps to this word bit; TX and RX share it so loopback is transparent.
    function automatic logic [CW-1:0] bit_pos(input logic [CW-1:0] idx);
        logic [CW-1:0] pos;
        if (LSB_FIRST) begin
            pos = idx;
        end else begin
            pos = LAST - idx;
        end
        return pos;
    endfunction

    tx_state_e        tx_state_r, tx_state_s;
    logic [CW-1:0]    tx_cnt_r, tx_cnt_s;
    logic [WIDTH-1:0] tx_sr_r, tx_sr_s;
    logic             ser_out_r, ser_out_s;
    logic             ser_frame_r, ser_frame_s;
    logic             tx_ready_s;
    logic             tx_load_s;

    logic             rx_frame_sel_s;
    logic             rx_bit_sel_s;
    logic [WIDTH-1:0] rx_word_s;
    logic [WIDTH-1:0] rx_first_s;
    logic [WIDTH-1:0] rx_sr_r;
    logic [WIDTH-1:0] rx_data_r;
    logic [CW-1:0]    rx_cnt_r;
    logic             rx_busy_r;
    logic             rx_valid_r;
    logic             rx_err_r;

    // TX next-state, bit counter and next serial output bit.
    always_comb begin
        tx_state_s  = tx_state_r;
        tx_cnt_s    = tx_cnt_r;
        tx_sr_s     = tx_sr_r;
        ser_out_s   = 1'b0;
        ser_frame_s = 1'b0;
        tx_ready_s  = (tx_state_r == TX_IDLE) ||
                      ((tx_state_r == TX_SHIFT) && (tx_cnt_r == LAST));
        tx_load_s   = tx_valid && tx_ready_s;
        if (tx_load_s) begin
            tx_state_s  = TX_SHIFT;
            tx_cnt_s    = ZERO;
            tx_sr_s     = tx_data;
            ser_out_s   = tx_data[bit_pos(ZERO)];
            ser_frame_s = 1'b1;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx_state_s = TX_IDLE;
                end
                TX_SHIFT: begin
                    if (tx_cnt_r == LAST) begin
                        tx_state_s = TX_IDLE;
                        tx_cnt_s   = ZERO;
                    end else begin
                        tx_cnt_s  = tx_cnt_r + ONE;
                        ser_out_s = tx_sr_r[bit_pos(tx_cnt_r + ONE)];
                    end
                end
                default: begin
                    tx_state_s = TX_IDLE;
                    tx_cnt_s   = ZERO;
                end
            endcase
        end
    end

    // TX state register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r  <= TX_IDLE;
            tx_cnt_r    <= ZERO;
            tx_sr_r     <= {WIDTH{1'b0}};
            ser_out_r   <= 1'b0;
            ser_frame_r <= 1'b0;
        end else begin
            tx_state_r  <= tx_state_s;
            tx_cnt_r    <= tx_cnt_s;
            tx_sr_r     <= tx_sr_s;
            ser_out_r   <= ser_out_s;
            ser_frame_r <= ser_frame_s;
        end
    end

    // RX source selection and word assembly with the currently sampled bit merged in.
    always_comb begin
        rx_frame_sel_s = loopback ? ser_frame_r : ser_frame_in;
        rx_bit_sel_s   = loopback ? ser_out_r   : ser_in;
        rx_word_s      = rx_sr_r;
        rx_word_s[bit_pos(rx_cnt_r)] = rx_bit_sel_s;
        rx_first_s     = {WIDTH{1'b0}};
        rx_first_s[bit_pos(ZERO)]    = rx_bit_sel_s;
    end

    // RX deserializer; a strobe while busy means the previous word was cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sr_r    <= {WIDTH{1'b0}};
            rx_data_r  <= {WIDTH{1'b0}};
            rx_cnt_r   <= ZERO;
            rx_busy_r  <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            if (rx_frame_sel_s) begin
                if (rx_busy_r) begin
                    rx_err_r <= 1'b1;
                end
                rx_sr_r   <= rx_first_s;
                rx_cnt_r  <= ONE;
                rx_busy_r <= 1'b1;
            end else if (rx_busy_r) begin
                if (rx_cnt_r == LAST) begin
                    rx_data_r  <= rx_word_s;
                    rx_valid_r <= 1'b1;
                    rx_busy_r  <= 1'b0;
                    rx_cnt_r   <= ZERO;
                end else begin
                    rx_sr_r  <= rx_word_s;
                    rx_cnt_r <= rx_cnt_r + ONE;
                end
            end
        end
    end

    assign tx_ready  = tx_ready_s;
    assign ser_out   = ser_out_r;
    assign ser_frame = ser_frame_r;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign rx_err    = rx_err_r;

endmodule

// File: tb/tb_serdes_framed.sv
// Self-checking bench for serdes_framed: directed vector table, hand-written corner sequences
// and randomized traffic against a queue/timeline reference model, on 8-bit and 12-bit instances.
module tb_serdes_framed;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic [7:0]  tx_data8 = 8'd0;
    logic        tx_valid8 = 1'b0, tx_ready8, ser_out8, ser_frame8;
    logic        ser_in8 = 1'b0, ser_frame_in8 = 1'b0, loopback8 = 1'b1;
    logic [7:0]  rx_data8;
    logic        rx_valid8, rx_err8;

    logic [11:0] tx_data12 = 12'd0;
    logic        tx_valid12 = 1'b0, tx_ready12, ser_out12, ser_frame12;
    logic        ser_in12 = 1'b0, ser_frame_in12 = 1'b0, loopback12 = 1'b1;
    logic [11:0] rx_data12;
    logic        rx_valid12, rx_err12;

    serdes_framed #(.WIDTH(8), .LSB_FIRST(1'b0)) dut8 (
        .clk(clk), .rst(rst), .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
        .ser_out(ser_out8), .ser_frame(ser_frame8), .ser_in(ser_in8),
        .ser_frame_in(ser_frame_in8), .loopback(loopback8), .rx_data(rx_data8),
        .rx_valid(rx_valid8), .rx_err(rx_err8)
    );

    serdes_framed #(.WIDTH(12), .LSB_FIRST(1'b1)) dut12 (
        .clk(clk), .rst(rst), .tx_data(tx_data12), .tx_valid(tx_valid12), .tx_ready(tx_ready12),
        .ser_out(ser_out12), .ser_frame(ser_frame12), .ser_in(ser_in12),
        .ser_frame_in(ser_frame_in12), .loopback(loopback12), .rx_data(rx_data12),
        .rx_valid(rx_valid12), .rx_err(rx_err12)
    );

    int checks = 0;
    int failures = 0;

    // Selects which instance the generic tasks drive and observe.
    bit use12 = 1'b0;
    logic        mon_ser_out, mon_frame, mon_ready, mon_rv, mon_err;
    logic [31:0] mon_rd;
    assign mon_ser_out = use12 ? ser_out12   : ser_out8;
    assign mon_frame   = use12 ? ser_frame12 : ser_frame8;
    assign mon_ready   = use12 ? tx_ready12  : tx_ready8;
    assign mon_rv      = use12 ? rx_valid12  : rx_valid8;
    assign mon_err     = use12 ? rx_err12    : rx_err8;
    assign mon_rd      = use12 ? {20'd0, rx_data12} : {24'd0, rx_data8};

    typedef struct {
        bit          use12;
        logic [31:0] word;
        logic [31:0] pat;   // expected serial stream, first bit in position WIDTH-1
    } vec_t;

    vec_t vecs[6];

    logic       exp_bit   [0:439];
    logic       exp_frame [0:439];
    logic       exp_rv    [0:439];
    logic [7:0] exp_rd    [0:439];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_tx(input logic v, input logic [31:0] d);
        if (use12) begin
            tx_valid12 = v;
            tx_data12  = d[11:0];
        end else begin
            tx_valid8 = v;
            tx_data8  = d[7:0];
        end
    endtask

    initial begin
        int          w;
        int          last_edge;
        logic [15:0] stream;
        logic [10:0] mf_frame;
        logic [10:0] mf_bits;
        logic [31:0] d;
        logic        v, f, b, exp_v, err_m;
        logic [11:0] rd_m;
        logic        q[$];
        int          gen_rem;

        vecs[0] = '{1'b0, 32'hA5,  32'b10100101};
        vecs[1] = '{1'b0, 32'h3C,  32'b00111100};
        vecs[2] = '{1'b0, 32'h00,  32'b00000000};
        vecs[3] = '{1'b0, 32'hFF,  32'b11111111};
        vecs[4] = '{1'b1, 32'h801, 32'b100000000001};
        vecs[5] = '{1'b1, 32'h123, 32'b110001001000};

        // Reset, then idle
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_ready8", tx_ready8, 1);
        chk("rst_ser_out8", ser_out8, 0);
        chk("rst_frame8", ser_frame8, 0);
        chk("rst_rv8", rx_valid8, 0);
        chk("rst_err8", rx_err8, 0);
        chk("rst_rd8", rx_data8, 0);
        chk("rst_ready12", tx_ready12, 1);
        chk("rst_rd12", rx_data12, 0);
        chk("rst_err12", rx_err12, 0);

        // Single loopback words from the vector table
        for (int n = 0; n < 6; n++) begin
            use12 = vecs[n].use12;
            w = use12 ? 12 : 8;
            chk("vec_ready_idle", mon_ready, 1);
            drive_tx(1'b1, vecs[n].word);
            step();
            drive_tx(1'b0, 32'd0);
            for (int i = 0; i < w; i++) begin
                chk("vec_bit", mon_ser_out, vecs[n].pat[w-1-i]);
                chk("vec_frame", mon_frame, (i == 0) ? 1 : 0);
                chk("vec_ready_busy", mon_ready, (i == w - 1) ? 1 : 0);
                chk("vec_rv_early", mon_rv, 0);
                step();
            end
            // handshake cycle plus WIDTH edges: rx_valid is the (WIDTH+1)th cycle
            chk("vec_rv", mon_rv, 1);
            chk("vec_rd", mon_rd, vecs[n].word);
            chk("vec_idle_out", mon_ser_out, 0);
            chk("vec_idle_frame", mon_frame, 0);
            step();
            chk("vec_rv_once", mon_rv, 0);
        end

        // Back-to-back words with tx_valid held high
        use12 = 1'b0;
        stream = {8'h3C, 8'hC3};
        drive_tx(1'b1, 32'h3C);
        step();
        for (int k = 0; k < 18; k++) begin
            chk("b2b_bit", mon_ser_out, (k < 16) ? stream[15-k] : 1'b0);
            chk("b2b_frame", mon_frame, (k == 0 || k == 8) ? 1 : 0);
            chk("b2b_ready", mon_ready, (k == 7 || k == 15 || k >= 16) ? 1 : 0);
            chk("b2b_rv", mon_rv, (k == 8 || k == 16) ? 1 : 0);
            if (k == 8) chk("b2b_rd0", mon_rd, 32'h3C);
            if (k == 16) chk("b2b_rd1", mon_rd, 32'hC3);
            if (k == 7) drive_tx(1'b1, 32'hC3);
            if (k == 8) drive_tx(1'b0, 32'd0);
            step();
        end

        // External RX with a strobe at bit 3 of a word in progress, then 0x81
        loopback8 = 1'b0;
        mf_frame = 11'b10010000000;
        mf_bits  = 11'b01010000001;
        for (int j = 0; j < 11; j++) begin
            ser_frame_in8 = mf_frame[10-j];
            ser_in8       = mf_bits[10-j];
            step();
            chk("mf_rv", mon_rv, (j == 10) ? 1 : 0);
            chk("mf_err", mon_err, (j >= 3) ? 1 : 0);
            if (j == 10) chk("mf_rd", mon_rd, 32'h81);
        end
        ser_frame_in8 = 1'b0;
        for (int j = 0; j < 20; j++) begin
            ser_in8 = 1'($urandom_range(0, 1));
            step();
            chk("mf_quiet_rv", mon_rv, 0);
        end
        chk("mf_err_sticky", mon_err, 1);
        chk("mf_rd_hold", mon_rd, 32'h81);

        // Reset mid-word
        rst = 1'b1;
        step();
        rst = 1'b0;
        loopback8 = 1'b1;
        ser_in8 = 1'b0;
        chk("rm_err_cleared", mon_err, 0);
        drive_tx(1'b1, 32'hFF);
        step();
        drive_tx(1'b0, 32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("rm_bit4", mon_ser_out, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rm_ser_out", mon_ser_out, 0);
        chk("rm_ready", mon_ready, 1);
        chk("rm_frame", mon_frame, 0);
        for (int i = 0; i < 14; i++) begin
            chk("rm_rv", mon_rv, 0);
            chk("rm_rd", mon_rd, 0);
            chk("rm_out_idle", mon_ser_out, 0);
            step();
        end

        // Random loopback traffic on the 8-bit instance against a per-edge timeline model
        use12 = 1'b0;
        for (int i = 0; i < 440; i++) begin
            exp_bit[i] = 1'b0;
            exp_frame[i] = 1'b0;
            exp_rv[i] = 1'b0;
            exp_rd[i] = 8'd0;
        end
        last_edge = -1;
        for (int k = 0; k < 410; k++) begin
            v = (k < 400) && ($urandom_range(0, 9) < 7);
            d = $urandom;
            drive_tx(v, d);
            if (v && k > last_edge) begin
                for (int i = 0; i < 8; i++) exp_bit[k+i] = d[7-i];
                exp_frame[k] = 1'b1;
                exp_rv[k+8] = 1'b1;
                exp_rd[k+8] = d[7:0];
                last_edge = k + 7;
            end
            step();
            chk("rl_bit", mon_ser_out, exp_bit[k]);
            chk("rl_frame", mon_frame, exp_frame[k]);
            chk("rl_ready", mon_ready, (k + 1 > last_edge) ? 1 : 0);
            chk("rl_rv", mon_rv, exp_rv[k]);
            if (exp_rv[k]) chk("rl_rd", mon_rd, {24'd0, exp_rd[k]});
        end
        drive_tx(1'b0, 32'd0);

        // Random external RX on the 12-bit LSB-first instance against a bit-queue model
        use12 = 1'b1;
        loopback12 = 1'b0;
        err_m = 1'b0;
        rd_m = 12'd0;
        gen_rem = 0;
        for (int k = 0; k < 400; k++) begin
            b = 1'($urandom_range(0, 1));
            if (gen_rem == 0) begin
                f = 1'($urandom_range(0, 1));
                if (f) gen_rem = 11;
            end else begin
                gen_rem--;
                f = ($urandom_range(0, 19) == 0);
                if (f) gen_rem = 11;
            end
            ser_frame_in12 = f;
            ser_in12 = b;
            step();
            exp_v = 1'b0;
            if (f) begin
                if (q.size() != 0) err_m = 1'b1;
                q.delete();
                q.push_back(b);
            end else if (q.size() != 0) begin
                q.push_back(b);
            end
            if (q.size() == 12) begin
                for (int i = 0; i < 12; i++) rd_m[i] = q[i];
                exp_v = 1'b1;
                q.delete();
            end
            chk("rx_rv", mon_rv, exp_v);
            chk("rx_rd", mon_rd, {20'd0, rd_m});
            chk("rx_err", mon_err, err_m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
